// File: rtl/usb_upload_framer.sv
// rtl/usb_upload_framer.sv - frames command/length/payload bytes onto the USB bulk IN upload stream; checksum byte enabled by macro UPLOAD_CHECKSUM_EN
module usb_upload_framer #(
    parameter int          PACE_DIV = 1,
    parameter logic [15:0] MAX_LEN  = 16'd4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_cmd,
    input  logic [15:0] i_len,
    input  logic [7:0]  i_pl_data,
    input  logic        i_pl_valid,
    output logic        o_pl_ready,
    output logic [7:0]  o_upload_data,
    output logic        o_upload_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        CMD,
        LENH,
        LENL,
        PAYLOAD,
        CSUM,
        DONE
    } state_t;

    // Pace counter reload: number of idle cycles that must follow a strobe.
    localparam logic [7:0] PACE_RELOAD = 8'(PACE_DIV - 1);

    // State that follows the last data-carrying byte of the frame.
`ifdef UPLOAD_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [7:0]  cmd_q;
    logic [15:0] len_q;
    logic [15:0] remaining;
    logic [7:0]  pace_cnt;
    logic [7:0]  pace_next;
    logic        hold_valid;
    logic [7:0]  hold_data;
    logic        err_q;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        pace_ok;
    logic        strobe;
    logic [7:0]  strobe_data;
    logic        ready;
    logic        accept;
    logic        start_ok;
    logic        start_bad;

    assign start_ok  = (state == IDLE) && i_start && (i_len <= MAX_LEN);
    assign start_bad = (state == IDLE) && i_start && (i_len > MAX_LEN);

    // Next-state, strobe selection, pacing and payload handshake.
    // A payload byte is accepted in the cycle before its strobe slot, so ready
    // is raised whenever the next cycle is a PAYLOAD slot the pace counter
    // allows -- including the LENL strobe cycle, which keeps PACE_DIV=1 frames
    // gap-free. A strobe in the reset cycle is suppressed so an aborted frame
    // emits nothing more.
    always_comb begin
        state_next  = state;
        strobe      = 1'b0;
        strobe_data = 8'h00;
        pace_ok     = (pace_cnt == 8'd0);
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = HDR0;
                end
            end
            HDR0: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = 8'hAA;
                    state_next  = HDR1;
                end
            end
            HDR1: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = 8'h55;
                    state_next  = CMD;
                end
            end
            CMD: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = cmd_q;
                    state_next  = LENH;
                end
            end
            LENH: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = len_q[15:8];
                    state_next  = LENL;
                end
            end
            LENL: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = len_q[7:0];
                    state_next  = (len_q == 16'd0) ? TAIL : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (hold_valid && pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = hold_data;
                    if (remaining == 16'd0) begin
                        state_next = TAIL;
                    end
                end
            end
`ifdef UPLOAD_CHECKSUM_EN
            CSUM: begin
                if (pace_ok) begin
                    strobe      = 1'b1;
                    strobe_data = csum_q;
                    state_next  = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (i_reset) begin
            strobe      = 1'b0;
            strobe_data = 8'h00;
        end

        if (strobe) begin
            pace_next = PACE_RELOAD;
        end else if (pace_cnt != 8'd0) begin
            pace_next = pace_cnt - 8'd1;
        end else begin
            pace_next = 8'd0;
        end

        ready  = !i_reset && (state_next == PAYLOAD) && (pace_next == 8'd0)
                 && (remaining != 16'd0);
        accept = ready && i_pl_valid;
    end

    assign o_upload_valid = strobe;
    assign o_upload_data  = strobe_data;
    assign o_pl_ready     = ready;
    assign o_busy         = (state != IDLE) && (state != DONE);
    assign o_done         = (state == DONE);
    assign o_err          = err_q;

    // Frame state, captured header fields, payload holding register and pace counter.
    // The pace counter keeps running across frame boundaries, so a start that
    // follows a frame within PACE_DIV cycles waits for the spacing to expire.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cmd_q      <= 8'h00;
            len_q      <= 16'd0;
            remaining  <= 16'd0;
            pace_cnt   <= 8'd0;
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            pace_cnt   <= pace_next;
            err_q      <= start_bad;
            hold_valid <= accept;
            if (start_ok) begin
                cmd_q     <= i_cmd;
                len_q     <= i_len;
                remaining <= i_len;
            end else if (accept) begin
                remaining <= remaining - 16'd1;
            end
            if (accept) begin
                hold_data <= i_pl_data;
            end
        end
    end

`ifdef UPLOAD_CHECKSUM_EN
    // Running modulo-256 sum over cmd, both length bytes and every accepted payload byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csum_q <= 8'h00;
        end else if (start_ok) begin
            csum_q <= i_cmd + i_len[15:8] + i_len[7:0];
        end else if (accept) begin
            csum_q <= csum_q + i_pl_data;
        end
    end
`endif

endmodule

// File: tb/tb_usb_upload_framer.sv
// tb/tb_usb_upload_framer.sv - scoreboard bench for usb_upload_framer (PACE_DIV=1 and PACE_DIV=4 instances)
module tb_usb_upload_framer;

    localparam int K_BYTE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         gap;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [7:0]  cmd;
    logic [15:0] len;
    logic [7:0]  pl_data;
    logic        pl_valid;

    logic        ready_a, up_valid_a, busy_a, done_a, err_a;
    logic [7:0]  up_data_a;
    logic        ready_b, up_valid_b, busy_b, done_b, err_b;
    logic [7:0]  up_data_b;

    evt_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          forbid_ready = 1'b0;
    bit          no_strobe = 1'b0;
    logic [7:0]  pl_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    usb_upload_framer #(.PACE_DIV(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_cmd(cmd), .i_len(len),
        .i_pl_data(pl_data), .i_pl_valid(pl_valid), .o_pl_ready(ready_a),
        .o_upload_data(up_data_a), .o_upload_valid(up_valid_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a)
    );

    usb_upload_framer #(.PACE_DIV(4)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_cmd(cmd), .i_len(len),
        .i_pl_data(pl_data), .i_pl_valid(pl_valid), .o_pl_ready(ready_b),
        .o_upload_data(up_data_b), .o_upload_valid(up_valid_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
    );

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input int g);
        evt_t e;
        e.kind = k;
        e.data = d;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic take(input int k, input logic [7:0] d);
        evt_t e;
        chk(exp_q.size() != 0, "unexpected_event", k, -1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk(e.kind == k, "event_kind", k, e.kind);
        if (k == K_BYTE) chk(d == e.data, "byte_value", d, e.data);
        if (e.gap > 0) chk(cyc - last_cyc == e.gap, "strobe_spacing", cyc - last_cyc, e.gap);
        last_cyc = cyc;
    endtask

    // Monitor: sample away from the active edge and retire scoreboard events.
    always @(negedge clk) begin
        chk(!(up_valid_a && up_valid_b), "single_active", {up_valid_a, up_valid_b}, 0);
        if (!up_valid_a) chk(up_data_a == 8'h00, "idle_data_a", up_data_a, 0);
        if (!up_valid_b) chk(up_data_b == 8'h00, "idle_data_b", up_data_b, 0);
        if (forbid_ready) chk(!(ready_a || ready_b), "ready_len0", {ready_a, ready_b}, 0);
        if (no_strobe) chk(!(up_valid_a || up_valid_b), "stall_strobe", {up_valid_a, up_valid_b}, 0);
        if (up_valid_a || up_valid_b) take(K_BYTE, up_valid_a ? up_data_a : up_data_b);
        if (done_a || done_b) take(K_DONE, 8'h00);
        if (err_a || err_b) take(K_ERR, 8'h00);
    end

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy_a || busy_b) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk(t < 500, "frame_timeout", t, 500);
        repeat (6) begin
            @(posedge clk); #1;
        end
    endtask

    // Issues one frame. cs is the hand-computed checksum. stall_at: payload index
    // preceded by a 10-cycle valid drop (with a spurious start injected). reset_at:
    // number of payload bytes accepted before a mid-frame reset (-1 for none).
    task automatic run_frame(input bit use_b, input logic [7:0] c, input logic [15:0] n,
                             input logic [7:0] cs, input int g, input int stall_at,
                             input int reset_at);
        bit accepted;
        int t;
        int nbytes;
        nbytes = (reset_at >= 0) ? reset_at : pl_q.size();
        push(K_BYTE, 8'hAA, 0);
        push(K_BYTE, 8'h55, g);
        push(K_BYTE, c, g);
        push(K_BYTE, n[15:8], g);
        push(K_BYTE, n[7:0], g);
        for (int i = 0; i < nbytes; i++) push(K_BYTE, pl_q[i], (i == stall_at) ? 0 : g);
        if (reset_at < 0) begin
`ifdef UPLOAD_CHECKSUM_EN
            push(K_BYTE, cs, g);
`endif
            push(K_DONE, 8'h00, 1);
        end

        cmd = c;
        len = n;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk((use_b ? busy_b : busy_a) == 1'b1, "busy_after_start", use_b ? busy_b : busy_a, 1);
        chk((use_b ? up_valid_b : up_valid_a) == 1'b1, "first_strobe_latency",
            use_b ? up_valid_b : up_valid_a, 1);

        for (int i = 0; i < pl_q.size(); i++) begin
            if (i == reset_at) begin
                pl_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk({ready_a, up_valid_a, up_data_a, busy_a, done_a, err_a} == 13'd0,
                    "reset_outputs_a", {ready_a, up_valid_a, up_data_a, busy_a, done_a, err_a}, 0);
                chk(exp_q.size() == 0, "reset_drained", exp_q.size(), 0);
                repeat (8) begin
                    @(posedge clk); #1;
                end
                return;
            end
            if (i == stall_at) begin
                pl_valid = 1'b0;
                @(posedge clk); #1;
                no_strobe = 1'b1;
                start_a = 1'b1;
                cmd = 8'h99;
                len = 16'd1;
                @(posedge clk); #1;
                start_a = 1'b0;
                repeat (8) begin
                    @(posedge clk); #1;
                end
                no_strobe = 1'b0;
            end
            pl_valid = 1'b1;
            pl_data  = pl_q[i];
            accepted = 1'b0;
            t = 0;
            while (!accepted && t < 200) begin
                @(negedge clk);
                if (use_b ? ready_b : ready_a) accepted = 1'b1;
                @(posedge clk); #1;
                t++;
            end
            chk(accepted, "payload_accept", t, 200);
        end
        pl_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        cmd = 8'h00;
        len = 16'd0;
        pl_data = 8'h00;
        pl_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk({ready_a, up_valid_a, up_data_a, busy_a, done_a, err_a} == 13'd0, "reset_state_a",
            {ready_a, up_valid_a, up_data_a, busy_a, done_a, err_a}, 0);
        chk({ready_b, up_valid_b, up_data_b, busy_b, done_b, err_b} == 13'd0, "reset_state_b",
            {ready_b, up_valid_b, up_data_b, busy_b, done_b, err_b}, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // cmd 12, len 3, 01 02 03: sum 12+00+03+01+02+03 = 1B, back-to-back
        pl_q = '{8'h01, 8'h02, 8'h03};
        run_frame(1'b0, 8'h12, 16'd3, 8'h1B, 1, -1, -1);

        // cmd 7F, len 0: sum 7F, ready must stay low
        pl_q.delete();
        forbid_ready = 1'b1;
        run_frame(1'b0, 8'h7F, 16'd0, 8'h7F, 1, -1, -1);
        forbid_ready = 1'b0;

        // PACE_DIV=4, cmd 01, len 2, FF FF: 01+00+02+FF+FF = 201 -> 01, 4-cycle spacing
        pl_q = '{8'hFF, 8'hFF};
        run_frame(1'b1, 8'h01, 16'd2, 8'h01, 4, -1, -1);

        // cmd 30, len 4, 10 20 30 40 with stall after second byte: sum D4
        pl_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_frame(1'b0, 8'h30, 16'd4, 8'hD4, 1, 2, -1);

        // oversize length is rejected with an error pulse and no frame
        cmd = 8'h11;
        len = 16'd4097;
        push(K_ERR, 8'h00, 0);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk(busy_a == 1'b0, "busy_after_err", busy_a, 0);
            @(posedge clk); #1;
        end
        chk(exp_q.size() == 0, "err_seen", exp_q.size(), 0);

        // reset after two payload bytes of a 5-byte frame
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame(1'b0, 8'h44, 16'd5, 8'h00, 1, -1, 2);

        // recovery frame: cmd 05, len 1, FA: 05+00+01+FA = 100 -> 00
        pl_q = '{8'hFA};
        run_frame(1'b0, 8'h05, 16'd1, 8'h00, 1, -1, -1);

        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
